// File: rtl/iter_counter.sv
// -----------------------------------------------------------------------------
// iter_counter
//
// Loadable iteration counter for the multiply/divide sequencing path. The
// control FSM loads it when an operation starts and steps it once per
// iteration. It counts down toward zero or up toward a captured terminal
// value. It can reload itself on terminal (AUTO_RELOAD=1) or stop in DONE
// (AUTO_RELOAD=0).
//
// Parameters
//   WIDTH       counter width in bits; arithmetic is modulo 2^WIDTH
//   AUTO_RELOAD 1 = reload the captured start value on terminal and keep
//               running, 0 = stop in DONE on terminal
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   load      in   capture load_val/dir/term_val and start a run
//   load_val  in   start count
//   dir       in   0 = count down toward 0, 1 = count up toward term_val
//   term_val  in   terminal count for up mode
//   en        in   step enable, one step per cycle while running
//   ct        out  current count (registered)
//   busy      out  high while running (registered)
//   tc        out  one-cycle pulse on each terminal step (registered)
//   c_end     out  sticky done, set on first terminal step, cleared by load
// -----------------------------------------------------------------------------
module iter_counter #(
  parameter int unsigned WIDTH       = 5,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] term_val,
  input  logic             en,
  output logic [WIDTH-1:0] ct,
  output logic             busy,
  output logic             tc,
  output logic             c_end
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ct_reg, ct_next;
  // Shadow copies of the load-time operands. Changes on dir or term_val
  // during a run have no effect until the next load.
  logic [WIDTH-1:0] start_reg, start_next;
  logic [WIDTH-1:0] term_reg, term_next;
  logic             dir_reg, dir_next;
  logic             tc_reg, tc_next;
  logic             c_end_reg, c_end_next;
  logic             busy_reg, busy_next;

  // Per-bit terminal comparison. Up mode matches the captured terminal.
  // Down mode matches all-zero.
  logic [WIDTH-1:0] up_match;
  logic [WIDTH-1:0] zero_match;
  logic             term_hit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cmp
      assign up_match[gi]   = ~(ct_reg[gi] ^ term_reg[gi]);
      assign zero_match[gi] = ~ct_reg[gi];
    end
  endgenerate

  assign term_hit = dir_reg ? (&up_match) : (&zero_match);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ct_next    = ct_reg;
    start_next = start_reg;
    term_next  = term_reg;
    dir_next   = dir_reg;
    c_end_next = c_end_reg;
    tc_next    = 1'b0;    // tc is a pulse and drops unless a terminal step fires

    if (load) begin
      // Load overrides any step in the same cycle, including a terminal one.
      ct_next    = load_val;
      start_next = load_val;
      term_next  = term_val;
      dir_next   = dir;
      c_end_next = 1'b0;
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (en) begin
            if (term_hit) begin
              tc_next    = 1'b1;
              c_end_next = 1'b1;
              if (AUTO_RELOAD) begin
                // The reload itself is the terminal step, so the run
                // continues without a bubble.
                ct_next = start_reg;
              end else begin
                state_next = ST_DONE;    // ct holds at the terminal value
              end
            end else if (dir_reg) begin
              ct_next = ct_reg + ONE;    // wraps from all-ones to zero
            end else begin
              ct_next = ct_reg - ONE;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // en is ignored outside RUN; everything holds.
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    busy_next = (state_next == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ct_reg    <= '0;
      start_reg <= '0;
      term_reg  <= '0;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
      c_end_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ct_reg    <= ct_next;
      start_reg <= start_next;
      term_reg  <= term_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
      c_end_reg <= c_end_next;
      busy_reg  <= busy_next;
    end
  end

  assign ct    = ct_reg;
  assign busy  = busy_reg;
  assign tc    = tc_reg;
  assign c_end = c_end_reg;

endmodule

// File: tb/tb_iter_counter.sv
// -----------------------------------------------------------------------------
// tb_iter_counter
//
// Three counters share one stimulus bus:
//   inst 0: WIDTH=5, AUTO_RELOAD=0
//   inst 1: WIDTH=4, AUTO_RELOAD=0
//   inst 2: WIDTH=5, AUTO_RELOAD=1
// Each scenario task pushes the expected output vector onto a scoreboard queue
// as it drives a cycle of stimulus. After the edge it pops that vector and
// compares it against the chosen instance.
// -----------------------------------------------------------------------------
module tb_iter_counter;

  typedef struct packed {
    logic [4:0] ct;
    logic       busy;
    logic       tc;
    logic       c_end;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [4:0] lv;
    logic       d;
    logic [4:0] tv;
    logic       e;
  } stim_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] load_val;
  logic       dir;
  logic [4:0] term_val;
  logic       en;

  logic [4:0] ct5, ct_ar;
  logic [3:0] ct4;
  logic       busy5, tc5, cend5;
  logic       busy4, tc4, cend4;
  logic       busy_ar, tc_ar, cend_ar;

  int checks = 0;
  int errors = 0;
  obs_t sb[$];

  iter_counter #(.WIDTH(5), .AUTO_RELOAD(1'b0)) dut5 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .dir(dir),
    .term_val(term_val), .en(en), .ct(ct5), .busy(busy5), .tc(tc5), .c_end(cend5)
  );

  iter_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut4 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val[3:0]), .dir(dir),
    .term_val(term_val[3:0]), .en(en), .ct(ct4), .busy(busy4), .tc(tc4), .c_end(cend4)
  );

  iter_counter #(.WIDTH(5), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .dir(dir),
    .term_val(term_val), .en(en), .ct(ct_ar), .busy(busy_ar), .tc(tc_ar), .c_end(cend_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_obs(int inst);
    case (inst)
      0:       return {ct5, busy5, tc5, cend5};
      1:       return {1'b0, ct4, busy4, tc4, cend4};
      default: return {ct_ar, busy_ar, tc_ar, cend_ar};
    endcase
  endfunction

  task automatic apply(input stim_t s);
    reset    = s.rst;
    load     = s.ld;
    load_val = s.lv;
    dir      = s.d;
    term_val = s.tv;
    en       = s.e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    obs_t exp, obs;
    apply('{rst:1'b1, ld:1'b1, lv:5'd17, d:1'b1, tv:5'd3, e:1'b1});
    for (int k = 0; k < 3; k++) sb.push_back('{ct:5'd0, busy:1'b0, tc:1'b0, c_end:1'b0});
    tick();
    for (int k = 0; k < 3; k++) begin
      exp = sb.pop_front();
      obs = get_obs(k);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset inst%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 k, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn reset inst%0d ct=%0d busy=%0b tc=%0b c_end=%0b", k, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_down();
    stim_t st[6];
    obs_t  ex[6];
    obs_t  exp, obs;
    st = '{'{1'b0,1'b1,5'd3,1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1}};
    ex = '{'{5'd3,1'b1,1'b0,1'b0},
           '{5'd2,1'b1,1'b0,1'b0},
           '{5'd1,1'b1,1'b0,1'b0},
           '{5'd0,1'b1,1'b0,1'b0},
           '{5'd0,1'b0,1'b1,1'b1},
           '{5'd0,1'b0,1'b0,1'b1}};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      exp = sb.pop_front();
      obs = get_obs(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL down step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn down step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  // The 4-bit counter wraps 14 -> 15 -> 0 -> 1. From step 2 on, term_val and
  // dir change on the bus; they must be ignored until the next load.
  task automatic test_up_wrap();
    stim_t st[6];
    obs_t  ex[6];
    obs_t  exp, obs;
    st = '{'{1'b0,1'b1,5'd14,1'b1,5'd1,1'b0},
           '{1'b0,1'b0,5'd0, 1'b1,5'd1,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1}};
    ex = '{'{5'd14,1'b1,1'b0,1'b0},
           '{5'd15,1'b1,1'b0,1'b0},
           '{5'd0, 1'b1,1'b0,1'b0},
           '{5'd1, 1'b1,1'b0,1'b0},
           '{5'd1, 1'b0,1'b1,1'b1},
           '{5'd1, 1'b0,1'b0,1'b1}};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      exp = sb.pop_front();
      obs = get_obs(1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL up_wrap step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn up_wrap step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_auto_reload();
    obs_t exp, obs;
    logic [4:0] seq_ct[11];
    seq_ct = '{5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd2, 5'd2};
    for (int i = 0; i < 11; i++) begin
      obs_t e;
      if (i == 0) apply('{1'b0,1'b1,5'd2,1'b0,5'd0,1'b0});
      else if (i == 10) apply('{1'b0,1'b0,5'd0,1'b0,5'd0,1'b0});
      else apply('{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1});
      e.ct    = seq_ct[i];
      e.busy  = 1'b1;
      e.tc    = (i == 3 || i == 6 || i == 9);
      e.c_end = (i >= 3);
      sb.push_back(e);
      tick();
      exp = sb.pop_front();
      obs = get_obs(2);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL auto_reload step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn auto_reload step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  // en pulses in IDLE, en toggling in RUN, then en pulses in DONE
  // (up mode 3 -> 4, where the counter stops at 4).
  task automatic test_gating();
    stim_t st[13];
    obs_t  ex[13];
    obs_t  exp, obs;
    st = '{'{1'b1,1'b0,5'd0,1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b1,5'd5,1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1},
           '{1'b0,1'b1,5'd3,1'b1,5'd4,1'b0},
           '{1'b0,1'b0,5'd0,1'b1,5'd4,1'b1},
           '{1'b0,1'b0,5'd0,1'b1,5'd4,1'b1},
           '{1'b0,1'b0,5'd0,1'b1,5'd4,1'b1},
           '{1'b0,1'b0,5'd0,1'b1,5'd4,1'b1}};
    ex = '{'{5'd0,1'b0,1'b0,1'b0},
           '{5'd0,1'b0,1'b0,1'b0},
           '{5'd0,1'b0,1'b0,1'b0},
           '{5'd5,1'b1,1'b0,1'b0},
           '{5'd4,1'b1,1'b0,1'b0},
           '{5'd4,1'b1,1'b0,1'b0},
           '{5'd4,1'b1,1'b0,1'b0},
           '{5'd3,1'b1,1'b0,1'b0},
           '{5'd3,1'b1,1'b0,1'b0},
           '{5'd4,1'b1,1'b0,1'b0},
           '{5'd4,1'b0,1'b1,1'b1},
           '{5'd4,1'b0,1'b0,1'b1},
           '{5'd4,1'b0,1'b0,1'b1}};
    for (int i = 0; i < 13; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      exp = sb.pop_front();
      obs = get_obs(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL gating step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn gating step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Steps in order:
  //   load on terminal step; reset mid-run at ct=7; reset together with load;
  //   back-to-back loads; load clearing a set c_end.
  task automatic test_priority();
    stim_t st[13];
    obs_t  ex[13];
    obs_t  exp, obs;
    st = '{'{1'b0,1'b1,5'd0, 1'b0,5'd0,1'b0},
           '{1'b0,1'b1,5'd9, 1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b1,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b1,5'd9, 1'b0,5'd0,1'b0},
           '{1'b1,1'b1,5'd12,1'b0,5'd0,1'b0},
           '{1'b0,1'b1,5'd10,1'b0,5'd0,1'b0},
           '{1'b0,1'b1,5'd20,1'b0,5'd0,1'b1},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b1,5'd0, 1'b0,5'd0,1'b0},
           '{1'b0,1'b0,5'd0, 1'b0,5'd0,1'b1},
           '{1'b0,1'b1,5'd5, 1'b0,5'd0,1'b0}};
    ex = '{'{5'd0, 1'b1,1'b0,1'b0},
           '{5'd9, 1'b1,1'b0,1'b0},
           '{5'd8, 1'b1,1'b0,1'b0},
           '{5'd7, 1'b1,1'b0,1'b0},
           '{5'd0, 1'b0,1'b0,1'b0},
           '{5'd9, 1'b1,1'b0,1'b0},
           '{5'd0, 1'b0,1'b0,1'b0},
           '{5'd10,1'b1,1'b0,1'b0},
           '{5'd20,1'b1,1'b0,1'b0},
           '{5'd19,1'b1,1'b0,1'b0},
           '{5'd0, 1'b1,1'b0,1'b0},
           '{5'd0, 1'b0,1'b1,1'b1},
           '{5'd5, 1'b1,1'b0,1'b0}};
    for (int i = 0; i < 13; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      exp = sb.pop_front();
      obs = get_obs(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL priority step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn priority step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Down from 0 terminates on the first enabled step. Down from 31 takes
  // exactly 32 enabled steps.
  task automatic test_edge();
    obs_t exp, obs;
    for (int i = 0; i < 36; i++) begin
      obs_t e;
      if (i == 0) begin
        apply('{1'b0,1'b1,5'd0,1'b0,5'd0,1'b0});
        e = '{5'd0, 1'b1, 1'b0, 1'b0};
      end else if (i == 1) begin
        apply('{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1});
        e = '{5'd0, 1'b0, 1'b1, 1'b1};
      end else if (i == 2) begin
        apply('{1'b0,1'b1,5'd31,1'b0,5'd0,1'b0});
        e = '{5'd31, 1'b1, 1'b0, 1'b0};
      end else begin
        // enabled step number k = i-2, valid for k = 1..33
        int k;
        k = i - 2;
        apply('{1'b0,1'b0,5'd0,1'b0,5'd0,1'b1});
        if (k <= 31)      e = '{5'(31 - k), 1'b1, 1'b0, 1'b0};
        else if (k == 32) e = '{5'd0, 1'b0, 1'b1, 1'b1};
        else              e = '{5'd0, 1'b0, 1'b0, 1'b1};
      end
      sb.push_back(e);
      tick();
      exp = sb.pop_front();
      obs = get_obs(0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL edge step%0d: got ct=%0d busy=%0b tc=%0b c_end=%0b, expected ct=%0d busy=%0b tc=%0b c_end=%0b",
                 i, obs.ct, obs.busy, obs.tc, obs.c_end, exp.ct, exp.busy, exp.tc, exp.c_end);
      end else
        $display("txn edge step%0d ct=%0d busy=%0b tc=%0b c_end=%0b", i, obs.ct, obs.busy, obs.tc, obs.c_end);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    dir      = 1'b0;
    term_val = '0;
    en       = 1'b0;

    test_reset();
    test_down();
    test_up_wrap();
    test_reset();
    test_auto_reload();
    test_gating();
    test_priority();
    test_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_counter.md
# iter_counter

Parametrised, loadable iteration counter for the multdiv sequencing path. It supersedes the fixed 5-bit divider counter with:
- configurable width;
- up or down counting per load;
- gated stepping;
- optional auto-reload;
- a one-cycle terminal pulse plus a sticky done flag.

The multiply/divide control FSM loads it at operation start and steps it once per iteration.

## Interface
- WIDTH, 5: counter width in bits; counts modulo 2^WIDTH.
- AUTO_RELOAD, 0: 1 = reload the captured start value on terminal and keep running; 0 = stop in DONE.

- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture load_val, dir and term_val; start a run.
- load_val  in  WIDTH  start count.
- dir  in  1  0 = count down toward 0; 1 = count up toward term_val.
- term_val  in  WIDTH  terminal count for up mode (ignored in down mode).
- en  in  1  step enable; one step per cycle while high in RUN.
- ct  out  WIDTH  current count (registered).
- busy  out  1  high in RUN.
- tc  out  1  one-cycle pulse, registered, on each terminal step.
- c_end  out  1  sticky done; set on first terminal step, cleared by load or reset.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: counting.
  - DONE: stopped at terminal; reachable only with AUTO_RELOAD=0.
- Load (any state, reset low):
  - ct <= load_val; store load_val, dir and term_val in shadow registers; state <= RUN.
  - c_end <= 0; tc <= 0.
- RUN with en=1 and load=0:
  - Terminal condition: down mode ct==0; up mode ct==stored term.
  - Not terminal, down: ct <= ct-1. Not terminal, up: ct <= ct+1, wrapping from 2^WIDTH-1 to 0.
  - Terminal step, AUTO_RELOAD=0: ct holds; tc <= 1; c_end <= 1; state <= DONE.
  - Terminal step, AUTO_RELOAD=1: ct <= stored load_val; tc <= 1; c_end <= 1; state stays RUN.
- RUN with en=0: everything holds; tc <= 0.
- IDLE and DONE: en is ignored; ct holds; tc <= 0.
- Down mode from load_val=N takes N+1 enabled steps to terminal, so N=0 terminates on the first enabled step.
- Up mode from load_val=S to term T takes ((T-S) mod 2^WIDTH)+1 enabled steps. If S>T the count wraps through 0.
- Shadow registers make mid-run changes on term_val or dir have no effect until the next load.
- Arithmetic is unsigned WIDTH-bit, with no carry-out.

## Timing
- Reset values (the cycle after reset is sampled high): ct=0, busy=0, tc=0, c_end=0, state IDLE, all shadow registers 0.
- All outputs are registered. Every state, ct, tc and c_end change is visible one cycle after the sampling edge.
- Load latency: 1 cycle. ct=load_val and busy=1 in the cycle after load is sampled.
- tc is high for exactly one cycle per terminal step. c_end rises in the same cycle as the first tc.
- busy falls in the same cycle tc rises (AUTO_RELOAD=0).
- Priority: reset > load > en.
  - load coincident with a terminal step: the load wins; no tc, and c_end stays 0.
  - Reset mid-run: returns to the IDLE reset values next cycle with no tc.
- Back-to-back loads: the last load wins; each load restarts the run.
- Consecutive enabled cycles step every cycle with no bubbles. With AUTO_RELOAD=1, the reload cycle counts as the terminal step.

## Test plan
- Down count, WIDTH=5:
  - Stimulus: reset; load_val=3, dir=0; then en held high.
  - Expected: ct = 3, 2, 1, 0, 0; tc pulses once on the 4th enabled step; c_end=1 and busy=0 from then; further en leaves ct=0 and tc=0.
- Up with wrap, WIDTH=4:
  - Stimulus: load_val=14, term_val=1, dir=1; en high.
  - Expected: ct = 14, 15, 0, 1; tc after 4 enabled steps; a term_val change mid-run is ignored.
- Auto-reload, AUTO_RELOAD=1, WIDTH=5:
  - Stimulus: load_val=2, dir=0; en high for 9 cycles.
  - Expected: ct = 2, 1, 0, 2, 1, 0, 2, 1, 0, 2; tc pulses on the steps that reload 0 to 2 (3 pulses); c_end stays 1; busy stays 1.
- Gating and ordering:
  - Stimulus: en toggled 1,0,0,1 from load_val=5, dir=0.
  - Expected: ct = 5, 4, 4, 4, 3; en pulses in IDLE and DONE leave ct unchanged.
- Priority:
  - Load asserted on a terminal step: ct=load_val, tc=0, c_end=0.
  - Reset asserted mid-run at ct=7: next cycle ct=0, busy=0, c_end=0, tc=0.
  - Reset and load together: reset values.
- Edge values:
  - Down load_val=0: first enabled step gives tc and c_end.
  - Down load_val=2^WIDTH-1 (31): tc after exactly 32 enabled steps.
